lc3_fetch_branch_ctrl: RTL

//  Fetch/decode/branch sequencer for the LC-3 datapath. Owns the PC and drives the fetch strobes.

---
 rtl/lc3_fetch_branch_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lc3_fetch_branch_ctrl.sv
// lc3_fetch_branch_ctrl
//   Fetch/decode/branch sequencer for the LC-3 datapath. Owns the PC, drives the
//   fetch strobes, resolves BR locally from the registered branch-enable, and
//   hands every other opcode to the execute unit over a start/done handshake.
//
// Ports
//   clk_i          system clock, all state on rising edge
//   reset_i        synchronous active-high reset
//   run_i          1 = keep executing; sampled at instruction boundaries
//   ir_i[15:0]     instruction register (valid from DECODE onward)
//   ben_val_i      registered branch-enable from the BEN/NZP stage
//   mem_ready_i    memory read data valid this cycle
//   exec_done_i    execute unit finished the current instruction
//   load_pc_i      execute unit PC write, honoured only in EXEC
//   pc_in_i[15:0]  PC value for load_pc_i
//   pc_o[15:0]     program counter
//   gate_pc_o, ld_mar_o, mem_oe_o, ld_mdr_o, gate_mdr_o, ld_ir_o, ld_ben_o
//                  datapath strobes, decoded from state
//   exec_start_o   one-cycle start pulse to the execute unit
//   halted_o       1 while in HALTED
//   mem_err_o      sticky fetch-timeout flag, cleared only by reset
//   state_code_o   current state encoding (debug)
module lc3_fetch_branch_ctrl #(
    parameter logic [15:0]  PC_RESET    = 16'h3000,
    parameter int unsigned  MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic [15:0] ir_i,
    input  logic        ben_val_i,
    input  logic        mem_ready_i,
    input  logic        exec_done_i,
    input  logic        load_pc_i,
    input  logic [15:0] pc_in_i,
    output logic [15:0] pc_o,
    output logic        gate_pc_o,
    output logic        ld_mar_o,
    output logic        mem_oe_o,
    output logic        ld_mdr_o,
    output logic        gate_mdr_o,
    output logic        ld_ir_o,
    output logic        ld_ben_o,
    output logic        exec_start_o,
    output logic        halted_o,
    output logic        mem_err_o,
    output logic [3:0]  state_code_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    localparam logic [3:0] S_HALTED   = 4'd0;
    localparam logic [3:0] S_FETCH1   = 4'd1;
    localparam logic [3:0] S_FETCH2   = 4'd2;
    localparam logic [3:0] S_FETCH3   = 4'd3;
    localparam logic [3:0] S_DECODE   = 4'd4;
    localparam logic [3:0] S_BR       = 4'd5;
    localparam logic [3:0] S_BR_TAKEN = 4'd6;
    localparam logic [3:0] S_EXEC     = 4'd7;

    logic [3:0]       state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic [CNT_W-1:0] wait_cnt_inc;
    logic             fetch_timeout;
    logic             is_br;
    logic [15:0]      br_offset;
    logic [3:0]       boundary_state;
    logic             unused_ir;

    // IR[11:9] (nzp) is already folded into the externally registered BEN.
    assign unused_ir = ^ir_i[11:9];

    assign wait_cnt_inc   = wait_cnt_q + CNT_W'(1);
    assign fetch_timeout  = (wait_cnt_inc == TIMEOUT_CNT);
    assign is_br          = (ir_i[15:12] == 4'b0000);
    assign br_offset      = {{7{ir_i[8]}}, ir_i[8:0]};
    assign boundary_state = run_i ? S_FETCH1 : S_HALTED;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED: begin
                // A fetch fault holds the sequencer here until reset.
                if (run_i && !mem_err_q) begin
                    state_d = S_FETCH1;
                end
            end
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                if (mem_ready_i) begin
                    state_d = S_FETCH3;
                end else if (fetch_timeout) begin
                    state_d = S_HALTED;
                end
            end
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: state_d = is_br ? S_BR : S_EXEC;
            S_BR:     state_d = ben_val_i ? S_BR_TAKEN : boundary_state;
            S_BR_TAKEN: state_d = boundary_state;
            S_EXEC: begin
                if (exec_done_i) begin
                    state_d = boundary_state;
                end
            end
            default:  state_d = S_HALTED;
        endcase
    end

    // Output decode; only ld_mdr and exec_start look past the state
    always_comb begin
        gate_pc_o    = 1'b0;
        ld_mar_o     = 1'b0;
        mem_oe_o     = 1'b0;
        ld_mdr_o     = 1'b0;
        gate_mdr_o   = 1'b0;
        ld_ir_o      = 1'b0;
        ld_ben_o     = 1'b0;
        exec_start_o = 1'b0;
        halted_o     = 1'b0;
        case (state_q)
            S_HALTED: halted_o = 1'b1;
            S_FETCH1: begin
                gate_pc_o = 1'b1;
                ld_mar_o  = 1'b1;
            end
            S_FETCH2: begin
                mem_oe_o = 1'b1;
                ld_mdr_o = mem_ready_i;
            end
            S_FETCH3: begin
                gate_mdr_o = 1'b1;
                ld_ir_o    = 1'b1;
            end
            S_DECODE: begin
                ld_ben_o     = 1'b1;
                exec_start_o = !is_br;
            end
            default: ;
        endcase
    end

    // PC, fetch wait counter and fault flag update
    always_comb begin
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            S_FETCH1: begin
                pc_d       = pc_q + 16'd1;
                wait_cnt_d = '0;
            end
            S_FETCH2: begin
                if (!mem_ready_i) begin
                    wait_cnt_d = wait_cnt_inc;
                    if (fetch_timeout) begin
                        mem_err_d = 1'b1;
                    end
                end
            end
            S_BR_TAKEN: pc_d = pc_q + br_offset;
            S_EXEC: begin
                if (load_pc_i) begin
                    pc_d = pc_in_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q       <= PC_RESET;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign pc_o         = pc_q;
    assign mem_err_o    = mem_err_q;
    assign state_code_o = state_q;

endmodule
